// File: rtl/stream_width_serializer_if.sv
// Handshake bundle for stream_width_serializer.
// Carries the wide input stream (in_valid/in_ready/in_data) and the narrow
// output stream (out_valid/out_ready/out_data/out_last).
//   slave  : serializer view (consumes in_*, produces out_*)
//   master : environment view (produces in_*, consumes out_*)
interface stream_width_serializer_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/stream_width_serializer.sv
// stream_width_serializer: accepts one IN_WIDTH word per input handshake and
// emits it as RATIO = IN_WIDTH/OUT_WIDTH beats, flagging the final beat with
// out_last. A new word can be taken in the cycle the previous word's last
// beat is consumed, so sustained throughput has no bubble between words.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   s_if   : slave modport of stream_width_serializer_if
//            in_valid/in_ready/in_data  - wide input stream
//            out_valid/out_ready/out_data/out_last - narrow output stream
module stream_width_serializer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int MSB_FIRST = 0
) (
  input logic                          clk,
  input logic                          reset,
  stream_width_serializer_if.slave     s_if
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
    $error("stream_width_serializer: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [IN_WIDTH-1:0] shreg_q, shreg_d;

  logic out_valid;
  logic out_last;
  logic in_ready;
  logic beat_hs;
  logic in_hs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      shreg_q    <= shreg_d;
    end
  end

  always_comb begin
    out_valid = (state_q == SHIFT);
    out_last  = out_valid && (beat_cnt_q == LAST_CNT);
    beat_hs   = out_valid && s_if.out_ready;
    // Combinational from out_ready: lets the next word load on the same edge
    // that retires the last beat of the current one.
    in_ready  = (state_q == IDLE) || (beat_hs && out_last);
    in_hs     = s_if.in_valid && in_ready;

    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    shreg_d    = shreg_q;

    unique case (state_q)
      IDLE: begin
        if (in_hs) begin
          shreg_d    = s_if.in_data;
          beat_cnt_d = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (beat_hs) begin
          if (!out_last) begin
            shreg_d    = (MSB_FIRST != 0) ? (shreg_q << OUT_WIDTH) : (shreg_q >> OUT_WIDTH);
            beat_cnt_d = beat_cnt_q + 1'b1;
          end else if (in_hs) begin
            shreg_d    = s_if.in_data;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = '0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_if.out_valid = out_valid;
  assign s_if.out_last  = out_last;
  assign s_if.in_ready  = in_ready;
  assign s_if.out_data  = (MSB_FIRST != 0) ? shreg_q[IN_WIDTH-1 -: OUT_WIDTH]
                                           : shreg_q[OUT_WIDTH-1:0];

endmodule
